ricosoc_uart_tx: RTL and testbench

RICOSOC_UART_TX -- requirements
Module: ricosoc_uart_tx

---
 rtl/ricosoc_uart_tx.sv | 151 +++++++++++++++
 tb/tb_ricosoc_uart_tx.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ricosoc_uart_tx.sv
// rtl/ricosoc_uart_tx.sv - FIFO-buffered UART transmitter, LSB first, one stop bit
// Optional even-parity bit enabled by defining RICOSOC_UART_TX_PARITY_EN.
module ricosoc_uart_tx #(
  parameter int DEFAULT_DIV = 106,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        cfg_div_we,
  input  logic [15:0]                 cfg_div_di,
  output logic [15:0]                 cfg_div_do,
  input  logic [7:0]                  in_data,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic                        ser_tx,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;
  localparam logic [LW-1:0] FULL_LEVEL = LW'(FIFO_DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t        state;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [LW-1:0] level;
  logic [15:0]   div_reg;
  logic [15:0]   div_lat;
  logic [15:0]   cnt;
  logic [7:0]    shreg;
  logic [2:0]    bit_idx;
  logic          ser_q;
  logic          push;
  logic          pop;
  logic          fifo_nonempty;
  logic          bit_end;
  logic [7:0]    head;
`ifdef RICOSOC_UART_TX_PARITY_EN
  logic          par_bit;
`endif

  assign head          = mem[rd_ptr];
  assign fifo_nonempty = (level != '0);
  assign in_ready      = (level < FULL_LEVEL);
  assign bit_end       = (cnt == div_lat - 16'd1);
  assign push          = !rst && in_valid && in_ready;
  // A pop always starts a new frame: from idle, or straight out of a finished stop bit.
  assign pop           = !rst && fifo_nonempty &&
                         ((state == S_IDLE) || ((state == S_STOP) && bit_end));

  assign fifo_level = level;
  assign ser_tx     = ser_q;
  assign busy       = (state != S_IDLE) || fifo_nonempty;
  assign cfg_div_do = div_reg;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_reg <= 16'(DEFAULT_DIV);
    end else if (cfg_div_we) begin
      div_reg <= (cfg_div_di < 16'd2) ? 16'd2 : cfg_div_di;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      ser_q   <= 1'b1;
      cnt     <= '0;
      div_lat <= 16'(DEFAULT_DIV);
      shreg   <= '0;
      bit_idx <= '0;
`ifdef RICOSOC_UART_TX_PARITY_EN
      par_bit <= 1'b0;
`endif
    end else if (pop) begin
      // Divisor is sampled only here so mid-frame writes wait for the next frame.
      state   <= S_START;
      ser_q   <= 1'b0;
      cnt     <= '0;
      div_lat <= div_reg;
      shreg   <= head;
      bit_idx <= '0;
`ifdef RICOSOC_UART_TX_PARITY_EN
      par_bit <= ^head;
`endif
    end else begin
      if (state != S_IDLE) cnt <= bit_end ? 16'd0 : cnt + 16'd1;
      case (state)
        S_IDLE: ser_q <= 1'b1;
        S_START: if (bit_end) begin
          state   <= S_DATA;
          ser_q   <= shreg[0];
          shreg   <= shreg >> 1;
          bit_idx <= '0;
        end
        S_DATA: if (bit_end) begin
          if (bit_idx == 3'd7) begin
`ifdef RICOSOC_UART_TX_PARITY_EN
            state <= S_PARITY;
            ser_q <= par_bit;
`else
            state <= S_STOP;
            ser_q <= 1'b1;
`endif
          end else begin
            bit_idx <= bit_idx + 3'd1;
            ser_q   <= shreg[0];
            shreg   <= shreg >> 1;
          end
        end
`ifdef RICOSOC_UART_TX_PARITY_EN
        S_PARITY: if (bit_end) begin
          state <= S_STOP;
          ser_q <= 1'b1;
        end
`endif
        S_STOP: if (bit_end) begin
          state <= S_IDLE;
          ser_q <= 1'b1;
        end
        default: begin
          state <= S_IDLE;
          ser_q <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_ricosoc_uart_tx.sv
// tb/tb_ricosoc_uart_tx.sv - self-checking bench for ricosoc_uart_tx
module tb_ricosoc_uart_tx;
`ifdef RICOSOC_UART_TX_PARITY_EN
  localparam int NBITS  = 11;
  localparam bit PAR_EN = 1'b1;
`else
  localparam int NBITS  = 10;
  localparam bit PAR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_div_we;
  logic [15:0] cfg_div_di;
  logic [15:0] cfg_div_do;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        ser_tx;
  logic        busy;
  logic [3:0]  fifo_level;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ricosoc_uart_tx dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_div_we (cfg_div_we),
    .cfg_div_di (cfg_div_di),
    .cfg_div_do (cfg_div_do),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .ser_tx     (ser_tx),
    .busy       (busy),
    .fifo_level (fifo_level)
  );

  // Expected line levels of one frame, index = bit slot in time order.
  function automatic logic [10:0] model_frame(input logic [7:0] b);
    logic [10:0] f;
    f = '0;
    f[8:1] = b;
    if (PAR_EN) begin
      f[9]  = ^b;
      f[10] = 1'b1;
    end else begin
      f[9] = 1'b1;
    end
    return f;
  endfunction

  // Called at the first negedge showing the start bit; returns at the negedge after the frame.
  task automatic sample_frame(input int d, output logic [10:0] bits, output int glitches,
                              output logic busy_last);
    bits = '0;
    glitches = 0;
    busy_last = 1'b0;
    for (int i = 0; i < NBITS * d; i++) begin
      if (i > 0) @(negedge clk);
      if (i % d == 0) bits[i / d] = ser_tx;
      else if (ser_tx !== bits[i / d]) glitches++;
      if (i == NBITS * d - 1) busy_last = busy;
    end
    @(negedge clk);
  endtask

  task automatic write_div(input logic [15:0] v);
    cfg_div_di = v;
    cfg_div_we = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cfg_div_we = 1'b0;
  endtask

  task automatic push_byte(input logic [7:0] b);
    in_data  = b;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; cfg_div_we = 1'b0; in_data = '0; cfg_div_di = '0;
    repeat (3) @(negedge clk);
    n_tests++; if (ser_tx !== 1'b1) begin n_fail++; $display("FAIL reset_ser_tx: got %b expected 1", ser_tx); end
    n_tests++; if (fifo_level !== 4'd0) begin n_fail++; $display("FAIL reset_level: got %0d expected 0", fifo_level); end
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_tests++; if (cfg_div_do !== 16'd106) begin n_fail++; $display("FAIL reset_div: got %0d expected 106", cfg_div_do); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_frame(input logic [7:0] b, input string nm);
    logic [10:0] seen;
    int gl;
    logic bl;
    push_byte(b);
    n_tests++; if (ser_tx !== 1'b1 || busy !== 1'b1 || fifo_level !== 4'd1) begin
      n_fail++; $display("FAIL %s_accept: ser_tx %b busy %b level %0d expected 1 1 1", nm, ser_tx, busy, fifo_level); end
    @(negedge clk);
    n_tests++; if (ser_tx !== 1'b0) begin n_fail++; $display("FAIL %s_start: got %b expected 0", nm, ser_tx); end
    sample_frame(106, seen, gl, bl);
    n_tests++; if (seen !== model_frame(b) || gl !== 0) begin
      n_fail++; $display("FAIL %s_bits: got %h glitches %0d expected %h", nm, seen, gl, model_frame(b)); end
    n_tests++; if (seen[8:1] !== b) begin n_fail++; $display("FAIL %s_decode: got %h expected %h", nm, seen[8:1], b); end
    n_tests++; if (bl !== 1'b1 || busy !== 1'b0 || ser_tx !== 1'b1) begin
      n_fail++; $display("FAIL %s_length: busy_last %b busy %b ser_tx %b expected 1 0 1", nm, bl, busy, ser_tx); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] q [10];
    logic [7:0] base;
    logic [10:0] seen;
    int gl;
    logic bl;
    int k;
    int t0;
    base = 8'($urandom_range(0, 255));
    for (int i = 0; i < 10; i++) q[i] = base + 8'(i * 37);
    k = 0;
    fork
      begin
        int iter;
        logic acc;
        iter = 0;
        while (k < 10 && iter < 12000) begin
          in_data = q[k]; in_valid = 1'b1; acc = in_ready;
          @(posedge clk);
          if (acc) k++;
          @(negedge clk);
          iter++;
        end
        in_valid = 1'b0;
      end
      begin
        @(negedge clk);
        @(negedge clk);
        n_tests++; if (ser_tx !== 1'b0) begin n_fail++; $display("FAIL b2b_first_start: got %b expected 0", ser_tx); end
        t0 = cyc;
        for (int f = 0; f < 10; f++) begin
          sample_frame(106, seen, gl, bl);
          n_tests++; if (seen !== model_frame(q[f]) || gl !== 0 || bl !== 1'b1) begin
            n_fail++; $display("FAIL b2b_frame%0d: got %h glitches %0d busy_last %b expected %h", f, seen, gl, bl, model_frame(q[f])); end
          if (f == 0) begin
            n_tests++; if (k !== 9) begin n_fail++; $display("FAIL b2b_accepted: got %0d expected 9", k); end
            n_tests++; if (fifo_level !== 4'd7 || in_ready !== 1'b1) begin
              n_fail++; $display("FAIL b2b_level: got %0d ready %b expected 7 1", fifo_level, in_ready); end
          end
          if (f == 8) begin
            n_tests++; if (cyc - t0 !== 9 * NBITS * 106) begin
              n_fail++; $display("FAIL b2b_duration: got %0d expected %0d", cyc - t0, 9 * NBITS * 106); end
          end
          if (f < 9) begin
            n_tests++; if (ser_tx !== 1'b0) begin n_fail++; $display("FAIL b2b_gap%0d: got %b expected 0", f, ser_tx); end
          end
        end
        n_tests++; if (ser_tx !== 1'b1 || busy !== 1'b0 || k !== 10) begin
          n_fail++; $display("FAIL b2b_end: ser_tx %b busy %b accepted %0d expected 1 0 10", ser_tx, busy, k); end
      end
    join
  endtask

  task automatic test_div_clamp();
    logic [10:0] seen;
    int gl;
    logic bl;
    write_div(16'd0);
    n_tests++; if (cfg_div_do !== 16'd2) begin n_fail++; $display("FAIL clamp0: got %0d expected 2", cfg_div_do); end
    write_div(16'd1);
    n_tests++; if (cfg_div_do !== 16'd2) begin n_fail++; $display("FAIL clamp1: got %0d expected 2", cfg_div_do); end
    write_div(16'd20);
    n_tests++; if (cfg_div_do !== 16'd20) begin n_fail++; $display("FAIL div20: got %0d expected 20", cfg_div_do); end
    push_byte(8'hA3);
    @(negedge clk);
    n_tests++; if (ser_tx !== 1'b0) begin n_fail++; $display("FAIL div20_start: got %b expected 0", ser_tx); end
    sample_frame(20, seen, gl, bl);
    n_tests++; if (seen !== model_frame(8'hA3) || gl !== 0 || bl !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL div20_frame: got %h glitches %0d busy_last %b busy %b expected %h", seen, gl, bl, busy, model_frame(8'hA3)); end
  endtask

  task automatic test_div_midframe();
    logic [7:0] a;
    logic [7:0] b;
    logic [10:0] seen;
    int gl;
    logic bl;
    write_div(16'd106);
    a = 8'($urandom_range(0, 255));
    b = 8'($urandom_range(0, 255));
    in_data = a; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_data = b;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    n_tests++; if (ser_tx !== 1'b0) begin n_fail++; $display("FAIL mid_start: got %b expected 0", ser_tx); end
    fork
      sample_frame(106, seen, gl, bl);
      begin
        repeat (300) @(negedge clk);
        cfg_div_di = 16'd50; cfg_div_we = 1'b1;
        @(negedge clk);
        cfg_div_we = 1'b0;
      end
    join
    n_tests++; if (seen !== model_frame(a) || gl !== 0 || ser_tx !== 1'b0) begin
      n_fail++; $display("FAIL mid_frame1: got %h glitches %0d next %b expected %h", seen, gl, ser_tx, model_frame(a)); end
    n_tests++; if (cfg_div_do !== 16'd50) begin n_fail++; $display("FAIL mid_div: got %0d expected 50", cfg_div_do); end
    sample_frame(50, seen, gl, bl);
    n_tests++; if (seen !== model_frame(b) || gl !== 0 || bl !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL mid_frame2: got %h glitches %0d busy_last %b expected %h", seen, gl, bl, model_frame(b)); end
  endtask

  task automatic test_reset_midframe();
    int bad;
    for (int i = 0; i < 4; i++) begin
      in_data = 8'($urandom_range(0, 255)); in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
    end
    in_valid = 1'b0;
    n_tests++; if (fifo_level !== 4'd3 || ser_tx !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_queued: level %0d ser_tx %b expected 3 0", fifo_level, ser_tx); end
    repeat (150) @(negedge clk);
    rst = 1'b1; in_valid = 1'b1; in_data = 8'h5A; cfg_div_we = 1'b1; cfg_div_di = 16'd77;
    @(posedge clk);
    @(negedge clk);
    n_tests++; if (ser_tx !== 1'b1 || fifo_level !== 4'd0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_state: ser_tx %b level %0d busy %b ready %b expected 1 0 0 1", ser_tx, fifo_level, busy, in_ready); end
    n_tests++; if (cfg_div_do !== 16'd106) begin n_fail++; $display("FAIL rstmid_div: got %0d expected 106", cfg_div_do); end
    rst = 1'b0; in_valid = 1'b0; cfg_div_we = 1'b0;
    bad = 0;
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      if (ser_tx !== 1'b1 || busy !== 1'b0) bad++;
    end
    n_tests++; if (bad !== 0) begin n_fail++; $display("FAIL rstmid_quiet: got %0d active cycles expected 0", bad); end
  endtask

  task automatic test_random_frames();
    logic [7:0] b;
    logic [15:0] d;
    logic [10:0] seen;
    int gl;
    logic bl;
    for (int r = 0; r < 6; r++) begin
      d = (r == 0) ? 16'd2 : 16'($urandom_range(2, 12));
      b = 8'($urandom_range(0, 255));
      write_div(d);
      n_tests++; if (cfg_div_do !== d) begin n_fail++; $display("FAIL rnd_div%0d: got %0d expected %0d", r, cfg_div_do, d); end
      repeat ($urandom_range(0, 5)) @(negedge clk);
      push_byte(b);
      @(negedge clk);
      sample_frame(int'(d), seen, gl, bl);
      n_tests++; if (seen !== model_frame(b) || gl !== 0 || bl !== 1'b1 || busy !== 1'b0) begin
        n_fail++; $display("FAIL rnd_frame%0d: got %h glitches %0d busy_last %b busy %b expected %h div %0d", r, seen, gl, bl, busy, model_frame(b), d); end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_frame(8'h55, "u55");
    test_single_frame(8'h07, "par07");
    test_back_to_back();
    test_div_clamp();
    test_div_midframe();
    test_reset_midframe();
    test_random_frames();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
